bp_fe_lce_req_mshr: RTL and testbench

Parametrised successor to the front-end LCE request unit. It tracks up to `mshr_els_p` outstanding cache misses and uncached accesses at once, each in its own miss-status entry. It issues LCE→CCE requests and coherence-ack responses through arbitrated valid/ready ports and throttles the cache with a coherence timeout. It sits between the I$/D$ cache-service interface and the LCE request/response networks.

---
 rtl/bp_fe_lce_req_mshr.sv | 227 ++++++++++++++++++++++
 tb/tb_bp_fe_lce_req_mshr.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_lce_req_mshr.sv
// Multi-entry front-end LCE request unit: tracks outstanding misses and uncached
// accesses, issues LCE requests and coh_acks, and throttles the cache on a coherence timeout.
//
// state | meaning
// IDLE  | entry free for allocation
// SEND  | request captured, waiting for the request network
// WAIT  | request issued, collecting data/set_tag/wakeup or uc_done
// ACK   | miss complete, coh_ack pending on the response port
module bp_fe_lce_req_mshr #(
    parameter int paddr_width_p        = 40,
    parameter int lce_id_width_p       = 4,
    parameter int way_id_width_p       = 3,
    parameter int block_offset_width_p = 6,
    parameter int mshr_els_p           = 2,
    parameter int timeout_max_limit_p  = 4,
    localparam int mshr_id_width_lp    = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [lce_id_width_p-1:0]   lce_id_i,

    input  logic                        cache_req_v_i,
    output logic                        cache_req_ready_o,
    input  logic [1:0]                  cache_req_type_i,
    input  logic [paddr_width_p-1:0]    cache_req_addr_i,
    input  logic [1:0]                  cache_req_size_i,
    input  logic [63:0]                 cache_req_data_i,
    input  logic [way_id_width_p-1:0]   cache_req_way_i,
    input  logic                        cache_req_lru_dirty_i,

    output logic                        lce_req_v_o,
    input  logic                        lce_req_ready_i,
    output logic [1:0]                  lce_req_type_o,
    output logic [mshr_id_width_lp-1:0] lce_req_id_o,
    output logic [paddr_width_p-1:0]    lce_req_addr_o,
    output logic [1:0]                  lce_req_size_o,
    output logic [63:0]                 lce_req_data_o,
    output logic [way_id_width_p-1:0]   lce_req_way_o,
    output logic                        lce_req_lru_dirty_o,

    input  logic                        data_v_i,
    input  logic [mshr_id_width_lp-1:0] data_id_i,
    input  logic                        set_tag_v_i,
    input  logic [mshr_id_width_lp-1:0] set_tag_id_i,
    input  logic                        wakeup_v_i,
    input  logic [mshr_id_width_lp-1:0] wakeup_id_i,
    input  logic                        uc_done_v_i,
    input  logic [mshr_id_width_lp-1:0] uc_done_id_i,

    output logic                        lce_resp_v_o,
    input  logic                        lce_resp_yumi_i,
    output logic [paddr_width_p-1:0]    lce_resp_addr_o,

    input  logic                        coherence_blocked_i,
    input  logic                        cmd_ready_i,
    output logic                        busy_o
);

    typedef enum logic [1:0] {e_idle, e_send, e_wait, e_ack} state_e;

    localparam int tmo_width_lp = $clog2(timeout_max_limit_p + 1);
    localparam int tag_lsb_lp   = block_offset_width_p;

    state_e                      state_r    [mshr_els_p];
    logic [1:0]                  type_r     [mshr_els_p];
    logic [paddr_width_p-1:0]    addr_r     [mshr_els_p];
    logic [1:0]                  size_r     [mshr_els_p];
    logic [63:0]                 st_data_r  [mshr_els_p];
    logic [way_id_width_p-1:0]   way_r      [mshr_els_p];
    logic                        dirty_r    [mshr_els_p];
    logic                        data_r     [mshr_els_p];
    logic                        tag_r      [mshr_els_p];

    logic                        data_hit   [mshr_els_p];
    logic                        tag_hit    [mshr_els_p];
    logic                        wake_hit   [mshr_els_p];
    logic                        uc_hit     [mshr_els_p];

    logic                        alloc_v, send_v, ack_v, conflict, timeout;
    logic                        accept, req_fire;
    logic [mshr_id_width_lp-1:0] alloc_id, send_low_id, send_id, ack_id;
    logic                        req_lock_r;
    logic [mshr_id_width_lp-1:0] req_lock_id_r;
    logic [tmo_width_lp-1:0]     tmo_cnt_r;
    logic [paddr_width_p-1:0]    acc_addr;
    logic                        unused_lce_id;

    assign unused_lce_id = ^lce_id_i;

    // Reverse scan so the lowest index wins each priority pick.
    always_comb begin
        alloc_v     = 1'b0;
        alloc_id    = '0;
        send_v      = 1'b0;
        send_low_id = '0;
        ack_v       = 1'b0;
        ack_id      = '0;
        conflict    = 1'b0;
        busy_o      = 1'b0;
        for (int i = mshr_els_p - 1; i >= 0; i--) begin
            data_hit[i] = data_v_i    && (data_id_i    == mshr_id_width_lp'(i));
            tag_hit[i]  = set_tag_v_i && (set_tag_id_i == mshr_id_width_lp'(i));
            wake_hit[i] = wakeup_v_i  && (wakeup_id_i  == mshr_id_width_lp'(i));
            uc_hit[i]   = uc_done_v_i && (uc_done_id_i == mshr_id_width_lp'(i));
            if (state_r[i] == e_idle) begin
                alloc_v  = 1'b1;
                alloc_id = mshr_id_width_lp'(i);
            end
            if (state_r[i] == e_send) begin
                send_v      = 1'b1;
                send_low_id = mshr_id_width_lp'(i);
            end
            if (state_r[i] == e_ack) begin
                ack_v  = 1'b1;
                ack_id = mshr_id_width_lp'(i);
            end
            if (state_r[i] != e_idle) begin
                busy_o = 1'b1;
                if (addr_r[i][paddr_width_p-1:tag_lsb_lp] == cache_req_addr_i[paddr_width_p-1:tag_lsb_lp])
                    conflict = 1'b1;
            end
        end
    end

    assign timeout           = (tmo_cnt_r == '0);
    assign cache_req_ready_o = alloc_v & cmd_ready_i & ~timeout & ~conflict;
    assign accept            = cache_req_v_i & cache_req_ready_o;
    // A stalled request keeps its entry even if a lower entry enters SEND meanwhile.
    assign send_id           = req_lock_r ? req_lock_id_r : send_low_id;
    assign lce_req_v_o       = send_v;
    assign req_fire          = send_v & lce_req_ready_i;
    assign lce_resp_v_o      = ack_v;

    always_comb begin
        acc_addr = cache_req_addr_i;
        if (cache_req_type_i == 2'd0)
            acc_addr[tag_lsb_lp-1:0] = '0;
        else
            acc_addr = cache_req_addr_i & ~((paddr_width_p'(1) << cache_req_size_i) - paddr_width_p'(1));
    end

    always_comb begin
        lce_req_type_o      = '0;
        lce_req_id_o        = '0;
        lce_req_addr_o      = '0;
        lce_req_size_o      = '0;
        lce_req_data_o      = '0;
        lce_req_way_o       = '0;
        lce_req_lru_dirty_o = 1'b0;
        lce_resp_addr_o     = '0;
        if (send_v) begin
            lce_req_type_o      = type_r[send_id];
            lce_req_id_o        = send_id;
            lce_req_addr_o      = addr_r[send_id];
            lce_req_size_o      = size_r[send_id];
            lce_req_data_o      = st_data_r[send_id];
            lce_req_way_o       = way_r[send_id];
            lce_req_lru_dirty_o = dirty_r[send_id];
        end
        if (ack_v) begin
            lce_resp_addr_o                  = addr_r[ack_id];
            lce_resp_addr_o[tag_lsb_lp-1:0]  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < mshr_els_p; i++) begin
                state_r[i]   <= e_idle;
                type_r[i]    <= '0;
                addr_r[i]    <= '0;
                size_r[i]    <= '0;
                st_data_r[i] <= '0;
                way_r[i]     <= '0;
                dirty_r[i]   <= 1'b0;
                data_r[i]    <= 1'b0;
                tag_r[i]     <= 1'b0;
            end
            req_lock_r    <= 1'b0;
            req_lock_id_r <= '0;
            tmo_cnt_r     <= tmo_width_lp'(timeout_max_limit_p);
        end else begin
            for (int i = 0; i < mshr_els_p; i++) begin
                unique case (state_r[i])
                    e_idle: if (accept && alloc_id == mshr_id_width_lp'(i)) begin
                        type_r[i]    <= cache_req_type_i;
                        addr_r[i]    <= acc_addr;
                        size_r[i]    <= cache_req_size_i;
                        st_data_r[i] <= cache_req_data_i;
                        way_r[i]     <= cache_req_way_i;
                        dirty_r[i]   <= cache_req_lru_dirty_i;
                        data_r[i]    <= 1'b0;
                        tag_r[i]     <= 1'b0;
                        if (cache_req_type_i != 2'd3) state_r[i] <= e_send;
                    end
                    e_send: if (req_fire && send_id == mshr_id_width_lp'(i)) state_r[i] <= e_wait;
                    e_wait: if (type_r[i] == 2'd0) begin
                        if (wake_hit[i] || ((data_r[i] || data_hit[i]) && (tag_r[i] || tag_hit[i])))
                            state_r[i] <= e_ack;
                        else begin
                            data_r[i] <= data_r[i] | data_hit[i];
                            tag_r[i]  <= tag_r[i] | tag_hit[i];
                        end
                    end else if (uc_hit[i]) begin
                        state_r[i] <= e_idle;
                    end
                    e_ack: if (lce_resp_yumi_i && ack_id == mshr_id_width_lp'(i)) state_r[i] <= e_idle;
                    default: state_r[i] <= e_idle;
                endcase
            end

            if (send_v && !lce_req_ready_i) begin
                req_lock_r    <= 1'b1;
                req_lock_id_r <= send_id;
            end else begin
                req_lock_r    <= 1'b0;
            end

            // Down-counter: reaching zero means the limit of blocked cycles was hit.
            if (!coherence_blocked_i)
                tmo_cnt_r <= tmo_width_lp'(timeout_max_limit_p);
            else if (tmo_cnt_r != '0)
                tmo_cnt_r <= tmo_cnt_r - 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_fe_lce_req_mshr.sv
// Bench for bp_fe_lce_req_mshr: vector table, directed corner sequences and a
// randomized run against a transaction-level model of the miss-status entries.
module tb_bp_fe_lce_req_mshr;
    localparam int PW = 40, LW = 4, WW = 3, BO = 6, N = 2, IW = 1, TL = 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [LW-1:0] lce_id_i;
    logic          cache_req_v_i, cache_req_ready_o;
    logic [1:0]    cache_req_type_i;
    logic [PW-1:0] cache_req_addr_i;
    logic [1:0]    cache_req_size_i;
    logic [63:0]   cache_req_data_i;
    logic [WW-1:0] cache_req_way_i;
    logic          cache_req_lru_dirty_i;
    logic          lce_req_v_o, lce_req_ready_i;
    logic [1:0]    lce_req_type_o;
    logic [IW-1:0] lce_req_id_o;
    logic [PW-1:0] lce_req_addr_o;
    logic [1:0]    lce_req_size_o;
    logic [63:0]   lce_req_data_o;
    logic [WW-1:0] lce_req_way_o;
    logic          lce_req_lru_dirty_o;
    logic          data_v_i, set_tag_v_i, wakeup_v_i, uc_done_v_i;
    logic [IW-1:0] data_id_i, set_tag_id_i, wakeup_id_i, uc_done_id_i;
    logic          lce_resp_v_o, lce_resp_yumi_i;
    logic [PW-1:0] lce_resp_addr_o;
    logic          coherence_blocked_i, cmd_ready_i, busy_o;

    always #5 clk_i = ~clk_i;

    bp_fe_lce_req_mshr #(
        .paddr_width_p(PW), .lce_id_width_p(LW), .way_id_width_p(WW),
        .block_offset_width_p(BO), .mshr_els_p(N), .timeout_max_limit_p(TL)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
        .cache_req_v_i(cache_req_v_i), .cache_req_ready_o(cache_req_ready_o),
        .cache_req_type_i(cache_req_type_i), .cache_req_addr_i(cache_req_addr_i),
        .cache_req_size_i(cache_req_size_i), .cache_req_data_i(cache_req_data_i),
        .cache_req_way_i(cache_req_way_i), .cache_req_lru_dirty_i(cache_req_lru_dirty_i),
        .lce_req_v_o(lce_req_v_o), .lce_req_ready_i(lce_req_ready_i),
        .lce_req_type_o(lce_req_type_o), .lce_req_id_o(lce_req_id_o),
        .lce_req_addr_o(lce_req_addr_o), .lce_req_size_o(lce_req_size_o),
        .lce_req_data_o(lce_req_data_o), .lce_req_way_o(lce_req_way_o),
        .lce_req_lru_dirty_o(lce_req_lru_dirty_o),
        .data_v_i(data_v_i), .data_id_i(data_id_i),
        .set_tag_v_i(set_tag_v_i), .set_tag_id_i(set_tag_id_i),
        .wakeup_v_i(wakeup_v_i), .wakeup_id_i(wakeup_id_i),
        .uc_done_v_i(uc_done_v_i), .uc_done_id_i(uc_done_id_i),
        .lce_resp_v_o(lce_resp_v_o), .lce_resp_yumi_i(lce_resp_yumi_i),
        .lce_resp_addr_o(lce_resp_addr_o),
        .coherence_blocked_i(coherence_blocked_i), .cmd_ready_i(cmd_ready_i),
        .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        lce_id_i = 4'h3;
        cache_req_v_i = 0; cache_req_type_i = 0; cache_req_addr_i = '0; cache_req_size_i = 0;
        cache_req_data_i = '0; cache_req_way_i = 0; cache_req_lru_dirty_i = 0;
        lce_req_ready_i = 0;
        data_v_i = 0; set_tag_v_i = 0; wakeup_v_i = 0; uc_done_v_i = 0;
        data_id_i = 0; set_tag_id_i = 0; wakeup_id_i = 0; uc_done_id_i = 0;
        lce_resp_yumi_i = 0; coherence_blocked_i = 0; cmd_ready_i = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n_i = 0;
        tick();
        tick();
        reset_n_i = 1;
    endtask

    task automatic miss(input logic [PW-1:0] a);
        cache_req_v_i = 1; cache_req_type_i = 0; cache_req_addr_i = a;
    endtask

    // Vector table for the single-miss walk-through.
    typedef struct {
        logic cv; logic [1:0] ct; logic [PW-1:0] ca; logic [WW-1:0] cw;
        logic rr; logic dv; logic tv; logic yu;
        logic e_rq; logic [PW-1:0] e_a; logic [WW-1:0] e_w; logic e_rs; logic e_busy; logic e_rdy;
    } vec_t;

    function automatic vec_t mk(logic cv, logic [PW-1:0] ca, logic [WW-1:0] cw, logic rr, logic dv,
                                logic tv, logic yu, logic e_rq, logic [PW-1:0] e_a, logic [WW-1:0] e_w,
                                logic e_rs, logic e_busy, logic e_rdy);
        vec_t v;
        v.cv = cv; v.ct = 2'd0; v.ca = ca; v.cw = cw; v.rr = rr; v.dv = dv; v.tv = tv; v.yu = yu;
        v.e_rq = e_rq; v.e_a = e_a; v.e_w = e_w; v.e_rs = e_rs; v.e_busy = e_busy; v.e_rdy = e_rdy;
        return v;
    endfunction

    // Transaction-level model: one record per outstanding access.
    typedef struct {
        bit busy; bit issued; bit done; bit hd; bit ht;
        logic [1:0] kind; logic [PW-1:0] addr; logic [WW-1:0] way; logic [1:0] size;
        logic [63:0] data; logic dirty;
    } slot_t;

    slot_t m[N];
    slot_t pre[N];
    bit    hold;
    int    hold_id;
    int    run;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        logic [PW-1:0] blk[4];
        bit blk_mode;

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk("rst_req_v", 64'(lce_req_v_o), 64'(0));
        chk("rst_resp_v", 64'(lce_resp_v_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_req_addr", 64'(lce_req_addr_o), 64'(0));
        chk("rst_resp_addr", 64'(lce_resp_addr_o), 64'(0));
        chk("rst_ready_cmd1", 64'(cache_req_ready_o), 64'(1));
        cmd_ready_i = 0;
        #1;
        chk("rst_ready_cmd0", 64'(cache_req_ready_o), 64'(0));
        cmd_ready_i = 1;

        // ---------------- table: single miss ----------------
        tbl[0] = mk(1, 40'h8000_0044, 5, 0, 0, 0, 0,  0, 40'h0,          0, 0, 0, 1);
        tbl[1] = mk(0, 40'h0,         0, 1, 0, 0, 0,  1, 40'h8000_0040, 5, 0, 1, 1);
        tbl[2] = mk(0, 40'h8000_0048, 0, 1, 0, 0, 0,  0, 40'h0,          0, 0, 1, 0);
        tbl[3] = mk(0, 40'h8000_0080, 0, 1, 0, 0, 0,  0, 40'h0,          0, 0, 1, 1);
        tbl[4] = mk(0, 40'h0,         0, 1, 1, 0, 0,  0, 40'h0,          0, 0, 1, 1);
        tbl[5] = mk(0, 40'h0,         0, 1, 0, 0, 0,  0, 40'h0,          0, 0, 1, 1);
        tbl[6] = mk(0, 40'h0,         0, 1, 0, 1, 0,  0, 40'h0,          0, 0, 1, 1);
        tbl[7] = mk(0, 40'h0,         0, 1, 0, 0, 1,  0, 40'h8000_0040, 0, 1, 1, 1);
        tbl[8] = mk(0, 40'h0,         0, 1, 0, 0, 0,  0, 40'h0,          0, 0, 0, 1);
        do_reset();
        for (int k = 0; k < 9; k++) begin
            cache_req_v_i = tbl[k].cv; cache_req_type_i = tbl[k].ct; cache_req_addr_i = tbl[k].ca;
            cache_req_way_i = tbl[k].cw; lce_req_ready_i = tbl[k].rr;
            data_v_i = tbl[k].dv; set_tag_v_i = tbl[k].tv; lce_resp_yumi_i = tbl[k].yu;
            #1;
            chk($sformatf("tbl%0d_req_v", k), 64'(lce_req_v_o), 64'(tbl[k].e_rq));
            if (tbl[k].e_rq) begin
                chk($sformatf("tbl%0d_req_addr", k), 64'(lce_req_addr_o), 64'(tbl[k].e_a));
                chk($sformatf("tbl%0d_req_way", k), 64'(lce_req_way_o), 64'(tbl[k].e_w));
                chk($sformatf("tbl%0d_req_type", k), 64'(lce_req_type_o), 64'(0));
                chk($sformatf("tbl%0d_req_id", k), 64'(lce_req_id_o), 64'(0));
            end
            chk($sformatf("tbl%0d_resp_v", k), 64'(lce_resp_v_o), 64'(tbl[k].e_rs));
            if (tbl[k].e_rs)
                chk($sformatf("tbl%0d_resp_addr", k), 64'(lce_resp_addr_o), 64'(tbl[k].e_a));
            chk($sformatf("tbl%0d_busy", k), 64'(busy_o), 64'(tbl[k].e_busy));
            chk($sformatf("tbl%0d_ready", k), 64'(cache_req_ready_o), 64'(tbl[k].e_rdy));
            tick();
        end

        // ---------------- two outstanding ----------------
        do_reset();
        miss(40'h1000);
        #1; chk("two_rdy0", 64'(cache_req_ready_o), 64'(1));
        tick();
        miss(40'h2000);
        #1;
        chk("two_rdy1", 64'(cache_req_ready_o), 64'(1));
        chk("two_v_a", 64'(lce_req_v_o), 64'(1));
        chk("two_id_a", 64'(lce_req_id_o), 64'(0));
        chk("two_addr_a", 64'(lce_req_addr_o), 64'(40'h1000));
        tick();
        miss(40'h3000);
        #1;
        chk("two_rdy_full", 64'(cache_req_ready_o), 64'(0));
        chk("two_id_hold", 64'(lce_req_id_o), 64'(0));
        chk("two_addr_hold", 64'(lce_req_addr_o), 64'(40'h1000));
        tick();
        lce_req_ready_i = 1;
        #1;
        chk("two_id_b", 64'(lce_req_id_o), 64'(0));
        chk("two_addr_b", 64'(lce_req_addr_o), 64'(40'h1000));
        tick();
        #1;
        chk("two_v_c", 64'(lce_req_v_o), 64'(1));
        chk("two_id_c", 64'(lce_req_id_o), 64'(1));
        chk("two_addr_c", 64'(lce_req_addr_o), 64'(40'h2000));
        tick();
        #1;
        chk("two_v_d", 64'(lce_req_v_o), 64'(0));
        chk("two_rdy_stall", 64'(cache_req_ready_o), 64'(0));
        wakeup_v_i = 1; wakeup_id_i = 0;
        tick();
        wakeup_v_i = 0;
        #1;
        chk("two_resp_v", 64'(lce_resp_v_o), 64'(1));
        chk("two_resp_addr", 64'(lce_resp_addr_o), 64'(40'h1000));
        chk("two_rdy_ack", 64'(cache_req_ready_o), 64'(0));
        lce_resp_yumi_i = 1;
        tick();
        lce_resp_yumi_i = 0;
        #1;
        chk("two_resp_off", 64'(lce_resp_v_o), 64'(0));
        chk("two_rdy_free", 64'(cache_req_ready_o), 64'(1));
        tick();
        cache_req_v_i = 0;
        #1;
        chk("two_realloc_id", 64'(lce_req_id_o), 64'(0));
        chk("two_realloc_addr", 64'(lce_req_addr_o), 64'(40'h3000));

        // ---------------- uncached ----------------
        do_reset();
        cache_req_v_i = 1; cache_req_type_i = 1; cache_req_addr_i = 40'h1237; cache_req_size_i = 2;
        tick();
        cache_req_v_i = 0;
        #1;
        chk("uc_ld_type", 64'(lce_req_type_o), 64'(1));
        chk("uc_ld_addr", 64'(lce_req_addr_o), 64'(40'h1234));
        chk("uc_ld_size", 64'(lce_req_size_o), 64'(2));
        lce_req_ready_i = 1;
        tick();
        #1;
        chk("uc_ld_wait_busy", 64'(busy_o), 64'(1));
        uc_done_v_i = 1; uc_done_id_i = 0;
        tick();
        uc_done_v_i = 0;
        #1;
        chk("uc_ld_done_busy", 64'(busy_o), 64'(0));
        chk("uc_ld_no_resp", 64'(lce_resp_v_o), 64'(0));
        cache_req_v_i = 1; cache_req_type_i = 2; cache_req_addr_i = 40'h1233; cache_req_size_i = 1;
        cache_req_data_i = 64'hDEAD_BEEF_0123_4567; cache_req_way_i = 2; cache_req_lru_dirty_i = 1;
        tick();
        cache_req_v_i = 0;
        uc_done_v_i = 1;
        #1;
        chk("uc_st_type", 64'(lce_req_type_o), 64'(2));
        chk("uc_st_addr", 64'(lce_req_addr_o), 64'(40'h1232));
        chk("uc_st_data", lce_req_data_o, 64'hDEAD_BEEF_0123_4567);
        chk("uc_st_way", 64'(lce_req_way_o), 64'(2));
        chk("uc_st_dirty", 64'(lce_req_lru_dirty_o), 64'(1));
        tick();
        #1;
        chk("uc_done_in_send_ignored", 64'(busy_o), 64'(1));
        tick();
        uc_done_v_i = 0;
        #1;
        chk("uc_st_done_busy", 64'(busy_o), 64'(0));

        // ---------------- wakeup and stray events ----------------
        do_reset();
        data_v_i = 1; set_tag_v_i = 1;
        tick();
        data_v_i = 0; set_tag_v_i = 0;
        #1;
        chk("stray_busy", 64'(busy_o), 64'(0));
        chk("stray_resp", 64'(lce_resp_v_o), 64'(0));
        miss(40'h4010);
        tick();
        cache_req_v_i = 0;
        data_v_i = 1; set_tag_v_i = 1;
        tick();
        data_v_i = 0; set_tag_v_i = 0;
        lce_req_ready_i = 1;
        #1;
        chk("send_ev_req_v", 64'(lce_req_v_o), 64'(1));
        tick();
        #1;
        chk("send_ev_resp0", 64'(lce_resp_v_o), 64'(0));
        tick();
        #1;
        chk("send_ev_resp1", 64'(lce_resp_v_o), 64'(0));
        wakeup_v_i = 1;
        tick();
        wakeup_v_i = 0;
        #1;
        chk("wake_resp_v", 64'(lce_resp_v_o), 64'(1));
        chk("wake_resp_addr", 64'(lce_resp_addr_o), 64'(40'h4000));
        lce_resp_yumi_i = 1;
        tick();
        lce_resp_yumi_i = 0;
        #1;
        chk("wake_idle", 64'(busy_o), 64'(0));

        // ---------------- timeout ----------------
        do_reset();
        coherence_blocked_i = 1;
        #1;
        chk("tmo_c0", 64'(cache_req_ready_o), 64'(1));
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("tmo_c%0d", k), 64'(cache_req_ready_o), 64'(k < TL ? 1 : 0));
        end
        coherence_blocked_i = 0;
        #1;
        chk("tmo_low_same", 64'(cache_req_ready_o), 64'(0));
        tick();
        chk("tmo_restored", 64'(cache_req_ready_o), 64'(1));

        // ---------------- reset during ACK ----------------
        do_reset();
        miss(40'h5000);
        lce_req_ready_i = 1;
        tick();
        cache_req_v_i = 0;
        tick();
        wakeup_v_i = 1;
        tick();
        wakeup_v_i = 0;
        #1;
        chk("rack_resp_before", 64'(lce_resp_v_o), 64'(1));
        reset_n_i = 0;
        tick();
        chk("rack_resp_after", 64'(lce_resp_v_o), 64'(0));
        chk("rack_busy_after", 64'(busy_o), 64'(0));
        reset_n_i = 1;
        lce_req_ready_i = 0;
        tick();
        chk("rack_still_idle", 64'(busy_o), 64'(0));

        // ---------------- randomized vs model ----------------
        blk[0] = 40'h0_1000; blk[1] = 40'h0_1040; blk[2] = 40'h8000_0000; blk[3] = 40'h8000_0FC0;
        do_reset();
        for (int i = 0; i < N; i++) m[i] = '{default: 0};
        hold = 0; hold_id = 0; run = 0; blk_mode = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int req_idx, resp_idx, free_idx, r;
            bit conflict, exp_rdy;
            req_idx = -1; resp_idx = -1; free_idx = -1; conflict = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (!m[i].busy) free_idx = i;
                if (m[i].busy && !m[i].issued) req_idx = i;
                if (m[i].busy && m[i].issued && m[i].done) resp_idx = i;
            end
            if (hold) req_idx = hold_id;

            r = $urandom_range(0, 9);
            cache_req_v_i = $urandom_range(0, 1) == 1;
            cache_req_type_i = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            cache_req_addr_i = blk[$urandom_range(0, 3)] + 40'($urandom_range(0, 63));
            cache_req_size_i = 2'($urandom_range(0, 3));
            cache_req_data_i = {$urandom, $urandom};
            cache_req_way_i = 3'($urandom_range(0, 7));
            cache_req_lru_dirty_i = $urandom_range(0, 1) == 1;
            lce_req_ready_i = $urandom_range(0, 3) != 0;
            data_v_i = $urandom_range(0, 3) == 0;    data_id_i = 1'($urandom_range(0, 1));
            set_tag_v_i = $urandom_range(0, 3) == 0; set_tag_id_i = 1'($urandom_range(0, 1));
            wakeup_v_i = $urandom_range(0, 7) == 0;  wakeup_id_i = 1'($urandom_range(0, 1));
            uc_done_v_i = $urandom_range(0, 3) == 0; uc_done_id_i = 1'($urandom_range(0, 1));
            lce_resp_yumi_i = (resp_idx >= 0) && ($urandom_range(0, 1) == 1);
            cmd_ready_i = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 15) == 0) blk_mode = ~blk_mode;
            coherence_blocked_i = blk_mode;
            #1;

            for (int i = 0; i < N; i++)
                if (m[i].busy && (m[i].addr / 64) == (cache_req_addr_i / 64)) conflict = 1;
            exp_rdy = (free_idx >= 0) && cmd_ready_i && (run < TL) && !conflict;

            chk("rnd_ready", 64'(cache_req_ready_o), 64'(exp_rdy));
            chk("rnd_busy", 64'(busy_o), 64'(m[0].busy || m[1].busy));
            chk("rnd_req_v", 64'(lce_req_v_o), 64'(req_idx >= 0));
            if (req_idx >= 0) begin
                chk("rnd_req_id", 64'(lce_req_id_o), 64'(req_idx));
                chk("rnd_req_type", 64'(lce_req_type_o), 64'(m[req_idx].kind));
                chk("rnd_req_addr", 64'(lce_req_addr_o), 64'(m[req_idx].addr));
                chk("rnd_req_size", 64'(lce_req_size_o), 64'(m[req_idx].size));
                chk("rnd_req_data", lce_req_data_o, m[req_idx].data);
                chk("rnd_req_way", 64'(lce_req_way_o), 64'(m[req_idx].way));
                chk("rnd_req_dirty", 64'(lce_req_lru_dirty_o), 64'(m[req_idx].dirty));
            end
            chk("rnd_resp_v", 64'(lce_resp_v_o), 64'(resp_idx >= 0));
            if (resp_idx >= 0)
                chk("rnd_resp_addr", 64'(lce_resp_addr_o), 64'((m[resp_idx].addr / 64) * 64));

            pre = m;
            for (int i = 0; i < N; i++) begin
                if (pre[i].busy && pre[i].issued && !pre[i].done) begin
                    if (pre[i].kind == 2'd0) begin
                        bit hd, ht;
                        hd = pre[i].hd || (data_v_i && int'(data_id_i) == i);
                        ht = pre[i].ht || (set_tag_v_i && int'(set_tag_id_i) == i);
                        if ((wakeup_v_i && int'(wakeup_id_i) == i) || (hd && ht)) m[i].done = 1;
                        else begin m[i].hd = hd; m[i].ht = ht; end
                    end else if (uc_done_v_i && int'(uc_done_id_i) == i) begin
                        m[i].busy = 0;
                    end
                end
            end
            if (req_idx >= 0 && lce_req_ready_i) m[req_idx].issued = 1;
            hold = (req_idx >= 0) && !lce_req_ready_i;
            hold_id = req_idx;
            if (resp_idx >= 0 && lce_resp_yumi_i) m[resp_idx].busy = 0;
            if (cache_req_v_i && exp_rdy && cache_req_type_i != 2'd3) begin
                slot_t s;
                s = '{default: 0};
                s.busy = 1; s.kind = cache_req_type_i;
                s.addr = (cache_req_type_i == 2'd0) ? (cache_req_addr_i / 64) * 64
                       : cache_req_addr_i - (cache_req_addr_i % (40'd1 << cache_req_size_i));
                s.way = cache_req_way_i; s.size = cache_req_size_i;
                s.data = cache_req_data_i; s.dirty = cache_req_lru_dirty_i;
                m[free_idx] = s;
            end
            run = coherence_blocked_i ? ((run < TL) ? run + 1 : TL) : 0;
            tick();
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
